// File: rtl/bank_timing_array.sv
// Per-bank DRAM timing checker: judges each command against the pre-edge bank state, pulses accept/err next cycle.
// Latency: accept/err and state one cycle; read strobe T_CL cycles after the accept edge. No backpressure; illegal commands are dropped.
module bank_timing_array #(
  parameter int NBANKS = 8,
  parameter int BA_W   = $clog2(NBANKS),
  parameter int CW     = 8,
  parameter int T_RCD  = 17,
  parameter int T_RP   = 17,
  parameter int T_RAS  = 39,
  parameter int T_RFC  = 34,
  parameter int T_RRD  = 8,
  parameter int T_CL   = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [2:0]            cmd,
  input  logic [BA_W-1:0]       cmd_ba,
  output logic                  cmd_accept,
  output logic                  cmd_err,
  output logic [3*NBANKS-1:0]   bank_state,
  output logic                  all_idle,
  output logic                  rd_valid,
  output logic [BA_W-1:0]       rd_ba
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ACTG = 3'd1;
  localparam logic [2:0] ST_ACTV = 3'd2;
  localparam logic [2:0] ST_PRE  = 3'd3;
  localparam logic [2:0] ST_REF  = 3'd4;

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PR  = 3'd4;
  localparam logic [2:0] CMD_PRA = 3'd5;
  localparam logic [2:0] CMD_REF = 3'd6;

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [2:0]      state_q [NBANKS];
  logic [2:0]      state_d [NBANKS];
  logic [CW-1:0]   rcd_q [NBANKS];
  logic [CW-1:0]   rcd_d [NBANKS];
  logic [CW-1:0]   rp_q  [NBANKS];
  logic [CW-1:0]   rp_d  [NBANKS];
  logic [CW-1:0]   ras_q [NBANKS];
  logic [CW-1:0]   ras_d [NBANKS];
  logic [CW-1:0]   rfc_q, rfc_d;
  logic [CW-1:0]   rrd_q, rrd_d;
  logic            pipe_vld_q [T_CL];
  logic [BA_W-1:0] pipe_ba_q  [T_CL];
  logic            accept_q, err_q, rd_valid_q;
  logic [BA_W-1:0] rd_ba_q;

  logic            ba_ok, any_busy, pra_block, idle_all, legal, apply;
  logic [2:0]      tgt_state;
  logic [CW-1:0]   tgt_ras;

  always_comb begin
    ba_ok     = (32'(cmd_ba) < NBANKS);
    tgt_state = ba_ok ? state_q[cmd_ba] : ST_IDLE;
    tgt_ras   = ba_ok ? ras_q[cmd_ba] : '0;
    any_busy  = 1'b0;
    pra_block = 1'b0;
    idle_all  = 1'b1;
    for (int b = 0; b < NBANKS; b++) begin
      if (state_q[b] != ST_IDLE) idle_all = 1'b0;
      if (state_q[b] == ST_ACTG || state_q[b] == ST_PRE || state_q[b] == ST_REF) any_busy = 1'b1;
      if (state_q[b] == ST_ACTV && ras_q[b] != '0) pra_block = 1'b1;
    end
    case (cmd)
      CMD_NOP:        legal = 1'b1;
      CMD_ACT:        legal = ba_ok && tgt_state == ST_IDLE && rrd_q == '0;
      CMD_RD, CMD_WR: legal = ba_ok && tgt_state == ST_ACTV;
      CMD_PR:         legal = ba_ok && (tgt_state == ST_IDLE ||
                                        (tgt_state == ST_ACTV && tgt_ras == '0));
      CMD_PRA:        legal = !any_busy && !pra_block;
      CMD_REF:        legal = idle_all;
      default:        legal = 1'b0;
    endcase
    apply = cmd_valid && legal;
  end

  // Counter-driven transitions first, then the command overrides; a legal command never
  // targets a bank that is mid-transition, so the two never collide.
  always_comb begin
    rfc_d = rfc_q;
    if (state_q[0] == ST_REF && rfc_q != '0) rfc_d = rfc_q - ONE;
    rrd_d = (rrd_q != '0) ? rrd_q - ONE : rrd_q;
    if (apply && cmd == CMD_ACT) rrd_d = CW'(T_RRD);
    if (apply && cmd == CMD_REF) rfc_d = CW'(T_RFC);
    for (int b = 0; b < NBANKS; b++) begin
      state_d[b] = state_q[b];
      rcd_d[b]   = rcd_q[b];
      rp_d[b]    = rp_q[b];
      ras_d[b]   = (ras_q[b] != '0) ? ras_q[b] - ONE : ras_q[b];
      case (state_q[b])
        ST_ACTG: begin
          if (rcd_q[b] == ONE) state_d[b] = ST_ACTV;
          if (rcd_q[b] != '0)  rcd_d[b]   = rcd_q[b] - ONE;
        end
        ST_PRE: begin
          if (rp_q[b] == ONE) state_d[b] = ST_IDLE;
          if (rp_q[b] != '0)  rp_d[b]    = rp_q[b] - ONE;
        end
        ST_REF: if (rfc_q == ONE) state_d[b] = ST_IDLE;
        default: ;
      endcase
      if (apply) begin
        case (cmd)
          CMD_ACT: if (cmd_ba == BA_W'(b)) begin
            state_d[b] = ST_ACTG;
            rcd_d[b]   = CW'(T_RCD);
            ras_d[b]   = CW'(T_RAS);
          end
          CMD_PR: if (cmd_ba == BA_W'(b) && state_q[b] == ST_ACTV) begin
            state_d[b] = ST_PRE;
            rp_d[b]    = CW'(T_RP);
          end
          CMD_PRA: if (state_q[b] == ST_ACTV) begin
            state_d[b] = ST_PRE;
            rp_d[b]    = CW'(T_RP);
          end
          CMD_REF: state_d[b] = ST_REF;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int b = 0; b < NBANKS; b++) begin
        state_q[b] <= ST_IDLE;
        rcd_q[b]   <= '0;
        rp_q[b]    <= '0;
        ras_q[b]   <= '0;
      end
      for (int s = 0; s < T_CL; s++) begin
        pipe_vld_q[s] <= 1'b0;
        pipe_ba_q[s]  <= '0;
      end
      rfc_q      <= '0;
      rrd_q      <= '0;
      accept_q   <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_ba_q    <= '0;
    end else begin
      state_q <= state_d;
      rcd_q   <= rcd_d;
      rp_q    <= rp_d;
      ras_q   <= ras_d;
      rfc_q   <= rfc_d;
      rrd_q   <= rrd_d;
      pipe_vld_q[0] <= apply && cmd == CMD_RD;
      pipe_ba_q[0]  <= cmd_ba;
      for (int s = 1; s < T_CL; s++) begin
        pipe_vld_q[s] <= pipe_vld_q[s-1];
        pipe_ba_q[s]  <= pipe_ba_q[s-1];
      end
      accept_q   <= cmd_valid && legal;
      err_q      <= cmd_valid && !legal;
      rd_valid_q <= pipe_vld_q[T_CL-1];
      rd_ba_q    <= pipe_ba_q[T_CL-1];
    end
  end

  always_comb begin
    bank_state = '0;
    for (int b = 0; b < NBANKS; b++) bank_state[3*b +: 3] = state_q[b];
  end

  assign all_idle   = idle_all;
  assign cmd_accept = accept_q;
  assign cmd_err    = err_q;
  assign rd_valid   = rd_valid_q;
  assign rd_ba      = rd_ba_q;

endmodule
